// File: rtl/ahb_lite_dec_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_dec_mux
// Purpose  : AHB-lite address decoder and response mux with a table-driven
//            region map, a registered data-phase owner and a built-in
//            two-cycle ERROR default slave.
//            The optional hung-slave watchdog is enabled by the macro
//            AHB_DEC_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ahb_lite_dec_mux #(
   parameter int unsigned               NUM_SLV     = 4,
   parameter logic [NUM_SLV*32-1:0]     SLV_START   = {NUM_SLV{32'h0}},
   parameter logic [NUM_SLV*32-1:0]     SLV_END     = {NUM_SLV{32'h0}},
   parameter int unsigned               TIMEOUT_CYC = 256
) (
   input  logic                   pll_core_cpuclk,
   input  logic                   pad_cpu_rst,
   input  logic [31:0]            biu_pad_haddr,
   input  logic [2:0]             biu_pad_hburst,
   input  logic [3:0]             biu_pad_hprot,
   input  logic [2:0]             biu_pad_hsize,
   input  logic [1:0]             biu_pad_htrans,
   input  logic [31:0]            biu_pad_hwdata,
   input  logic                   biu_pad_hwrite,
   input  logic                   smpu_deny,
   output logic [31:0]            pad_biu_hrdata,
   output logic                   pad_biu_hready,
   output logic [1:0]             pad_biu_hresp,
   output logic                   hmastlock,
   output logic [NUM_SLV-1:0]     hsel_s,
   output logic [31:0]            haddr_s,
   output logic [2:0]             hburst_s,
   output logic [3:0]             hprot_s,
   output logic [2:0]             hsize_s,
   output logic [1:0]             htrans_s,
   output logic [31:0]            hwdata_s,
   output logic                   hwrite_s,
   output logic                   hready_s,
   input  logic [NUM_SLV*32-1:0]  hrdata_s,
   input  logic [NUM_SLV-1:0]     hreadyout_s,
   input  logic [NUM_SLV*2-1:0]   hresp_s,
   output logic                   timeout_irq
);

   localparam logic [1:0] D_IDLE    = 2'd0;
   localparam logic [1:0] D_ERR1    = 2'd1;
   localparam logic [1:0] D_ERR2    = 2'd2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   logic [NUM_SLV-1:0] match;
   logic [NUM_SLV-1:0] hsel_pri;
   logic               hit;
   logic               def_sel;
   logic               expire;
   logic [NUM_SLV:0]   dsel_q, dsel_d;
   logic [1:0]         dstate_q, dstate_d;
   logic               def_hready;
   logic [1:0]         def_hresp;

   assign hmastlock = 1'b0;
   assign haddr_s   = biu_pad_haddr;
   assign hburst_s  = biu_pad_hburst;
   assign hprot_s   = biu_pad_hprot;
   assign hsize_s   = biu_pad_hsize;
   assign htrans_s  = biu_pad_htrans;
   assign hwdata_s  = biu_pad_hwdata;
   assign hwrite_s  = biu_pad_hwrite;
   assign hready_s  = pad_biu_hready;

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_match
      assign match[i] = (biu_pad_haddr >= SLV_START[32*i +: 32]) &&
                        (biu_pad_haddr <= SLV_END[32*i +: 32]);
   end

   // Lowest matching index owns overlapping regions.
   always_comb begin
      hsel_pri = '0;
      hit      = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (match[i] && !hit) begin
            hsel_pri[i] = 1'b1;
            hit         = 1'b1;
         end
      end
   end

   assign hsel_s  = (biu_pad_htrans[1] && !smpu_deny) ? hsel_pri : '0;
   assign def_sel = biu_pad_htrans[1] && (smpu_deny || !hit);

   always_comb begin
      dsel_d = dsel_q;
      if (expire) begin
         dsel_d = {1'b1, {NUM_SLV{1'b0}}};
      end else if (pad_biu_hready) begin
         dsel_d = {def_sel, hsel_s};
      end
   end

   always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
      if (pad_cpu_rst) begin
         dsel_q   <= '0;
         dstate_q <= D_IDLE;
      end else begin
         dsel_q   <= dsel_d;
         dstate_q <= dstate_d;
      end
   end

   always_comb begin
      dstate_d = dstate_q;
      case (dstate_q)
         D_IDLE:  if (expire || (pad_biu_hready && def_sel)) dstate_d = D_ERR1;
         D_ERR1:  dstate_d = D_ERR2;
         D_ERR2:  dstate_d = (pad_biu_hready && def_sel) ? D_ERR1 : D_IDLE;
         default: dstate_d = D_IDLE;
      endcase
   end

   always_comb begin
      def_hready = (dstate_q != D_ERR1);
      def_hresp  = (dstate_q == D_IDLE) ? RESP_OKAY : RESP_ERR;
   end

   // dsel is one-hot or zero, so an OR-style mux is sufficient.
   always_comb begin
      pad_biu_hrdata = '0;
      pad_biu_hready = 1'b1;
      pad_biu_hresp  = RESP_OKAY;
      if (dsel_q[NUM_SLV]) begin
         pad_biu_hready = def_hready;
         pad_biu_hresp  = def_hresp;
      end else begin
         for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_q[i]) begin
               pad_biu_hrdata = hrdata_s[32*i +: 32];
               pad_biu_hready = hreadyout_s[i];
               pad_biu_hresp  = hresp_s[2*i +: 2];
            end
         end
      end
   end

`ifdef AHB_DEC_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        irq_q;
   logic        stall;

   // A dsel change only happens on hready=1 or on expiry, both of which clear.
   assign stall    = |(dsel_q[NUM_SLV-1:0] & ~hreadyout_s);
   assign expire   = stall && (wd_cnt_q == TO_LAST);
   assign wd_cnt_d = (stall && !expire) ? wd_cnt_q + 16'd1 : 16'd0;

   always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
      if (pad_cpu_rst) begin
         wd_cnt_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         irq_q    <= expire;
      end
   end

   assign timeout_irq = irq_q;
`else
   logic unused_cfg;

   assign expire      = 1'b0;
   assign timeout_irq = 1'b0;
   assign unused_cfg  = (TIMEOUT_CYC != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_dec_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_dec_mux
// Purpose  : Directed self-checking bench for ahb_lite_dec_mux (decode table
//            plus hand-written data-phase sequences).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_lite_dec_mux;

   localparam int unsigned NUM_SLV = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   haddr = '0;
   logic [2:0]    hburst = '0;
   logic [3:0]    hprot = 4'h3;
   logic [2:0]    hsize = 3'd2;
   logic [1:0]    htrans = 2'b00;
   logic [31:0]   hwdata = '0;
   logic          hwrite = 1'b0;
   logic          deny = 1'b0;
   logic [31:0]   hrdata;
   logic          hready;
   logic [1:0]    hresp;
   logic          hmastlock;
   logic [3:0]    hsel_s;
   logic [31:0]   haddr_s, hwdata_s;
   logic [2:0]    hburst_s, hsize_s;
   logic [3:0]    hprot_s;
   logic [1:0]    htrans_s;
   logic          hwrite_s, hready_s;
   logic [127:0]  hrdata_s = '0;
   logic [3:0]    hreadyout_s = 4'hF;
   logic [7:0]    hresp_s = '0;
   logic          timeout_irq;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_lite_dec_mux #(
      .NUM_SLV     (NUM_SLV),
      .SLV_START   ({32'h6000_0000, 32'h7000_0000, 32'h2000_0000, 32'h1000_0000}),
      .SLV_END     ({32'h7FFF_FFFF, 32'h7007_FFFF, 32'h2000_FFFF, 32'h1000_FFFF}),
      .TIMEOUT_CYC (8)
   ) dut (
      .pll_core_cpuclk (clk),
      .pad_cpu_rst     (rst),
      .biu_pad_haddr   (haddr),
      .biu_pad_hburst  (hburst),
      .biu_pad_hprot   (hprot),
      .biu_pad_hsize   (hsize),
      .biu_pad_htrans  (htrans),
      .biu_pad_hwdata  (hwdata),
      .biu_pad_hwrite  (hwrite),
      .smpu_deny       (deny),
      .pad_biu_hrdata  (hrdata),
      .pad_biu_hready  (hready),
      .pad_biu_hresp   (hresp),
      .hmastlock       (hmastlock),
      .hsel_s          (hsel_s),
      .haddr_s         (haddr_s),
      .hburst_s        (hburst_s),
      .hprot_s         (hprot_s),
      .hsize_s         (hsize_s),
      .htrans_s        (htrans_s),
      .hwdata_s        (hwdata_s),
      .hwrite_s        (hwrite_s),
      .hready_s        (hready_s),
      .hrdata_s        (hrdata_s),
      .hreadyout_s     (hreadyout_s),
      .hresp_s         (hresp_s),
      .timeout_irq     (timeout_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got timeout expected finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        deny;
      logic [3:0]  exp_hsel;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_resp(input string name, input logic rdy, input logic [1:0] rsp,
                           input logic [31:0] data);
      chk({name, "_hready"}, {31'd0, hready}, {31'd0, rdy});
      chk({name, "_hresp"},  {30'd0, hresp},  {30'd0, rsp});
      chk({name, "_hrdata"}, hrdata, data);
   endtask

   initial begin
      vecs[0]  = '{32'h7000_0010, 2'b10, 1'b0, 4'b0100};
      vecs[1]  = '{32'h1000_0000, 2'b10, 1'b0, 4'b0001};
      vecs[2]  = '{32'h1000_FFFF, 2'b10, 1'b0, 4'b0001};
      vecs[3]  = '{32'h1001_0000, 2'b10, 1'b0, 4'b0000};
      vecs[4]  = '{32'h7007_FFFF, 2'b10, 1'b0, 4'b0100};
      vecs[5]  = '{32'h7008_0000, 2'b10, 1'b0, 4'b1000};
      vecs[6]  = '{32'h6000_0000, 2'b10, 1'b0, 4'b1000};
      vecs[7]  = '{32'h2000_0100, 2'b11, 1'b0, 4'b0010};
      vecs[8]  = '{32'h2000_0100, 2'b01, 1'b0, 4'b0000};
      vecs[9]  = '{32'h7000_0010, 2'b00, 1'b0, 4'b0000};
      vecs[10] = '{32'h7000_0010, 2'b10, 1'b1, 4'b0000};
      vecs[11] = '{32'h9000_0000, 2'b10, 1'b0, 4'b0000};

      // Reset state
      smp();
      chk_resp("reset", 1'b1, 2'b00, 32'h0);
      chk("reset_hsel", {28'd0, hsel_s}, 32'h0);
      chk("reset_irq", {31'd0, timeout_irq}, 32'h0);
      chk("hmastlock", {31'd0, hmastlock}, 32'h0);
      cyc();
      rst = 1'b0;
      cyc();
      smp();
      chk_resp("idle", 1'b1, 2'b00, 32'h0);

      // Decode table; each transfer is flushed with IDLE cycles afterwards
      for (int v = 0; v < 12; v++) begin
         cyc();
         haddr  = vecs[v].addr;
         htrans = vecs[v].trans;
         deny   = vecs[v].deny;
         smp();
         chk($sformatf("dec%0d_hsel", v), {28'd0, hsel_s}, {28'd0, vecs[v].exp_hsel});
         chk($sformatf("dec%0d_haddr_s", v), haddr_s, vecs[v].addr);
         cyc();
         htrans = 2'b00;
         deny   = 1'b0;
         repeat (3) cyc();
      end

      // Slave 2 read, one wait state
      hrdata_s[95:64] = 32'h0BAD_0BAD;
      haddr  = 32'h7000_0010;
      htrans = 2'b10;
      smp();
      chk("s2_addr_hsel", {28'd0, hsel_s}, 32'h4);
      chk("s2_addr_hready", {31'd0, hready}, 32'h1);
      cyc();
      htrans = 2'b00;
      hreadyout_s[2] = 1'b0;
      smp();
      chk("s2_wait_hsel", {28'd0, hsel_s}, 32'h0);
      chk("s2_wait_hready", {31'd0, hready}, 32'h0);
      chk("s2_wait_hready_s", {31'd0, hready_s}, 32'h0);
      cyc();
      hreadyout_s[2] = 1'b1;
      hrdata_s[95:64] = 32'hDEAD_BEEF;
      smp();
      chk_resp("s2_data", 1'b1, 2'b00, 32'hDEAD_BEEF);
      cyc();
      smp();
      chk_resp("s2_after", 1'b1, 2'b00, 32'h0);

      // Unmapped, then IDLE: two-cycle ERROR
      cyc();
      haddr  = 32'h9000_0000;
      htrans = 2'b10;
      smp();
      chk("unm_hsel", {28'd0, hsel_s}, 32'h0);
      cyc();
      htrans = 2'b00;
      smp();
      chk_resp("unm_err1", 1'b0, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("unm_err2", 1'b1, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("unm_okay", 1'b1, 2'b00, 32'h0);

      // Mapped address denied by SMPU
      cyc();
      haddr  = 32'h7000_0010;
      htrans = 2'b10;
      deny   = 1'b1;
      smp();
      chk("deny_hsel", {28'd0, hsel_s}, 32'h0);
      cyc();
      htrans = 2'b00;
      deny   = 1'b0;
      smp();
      chk_resp("deny_err1", 1'b0, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("deny_err2", 1'b1, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("deny_okay", 1'b1, 2'b00, 32'h0);

      // Back-to-back default-slave transfers: ERR2 goes straight to ERR1
      cyc();
      haddr  = 32'h9000_0000;
      htrans = 2'b10;
      cyc();
      haddr  = 32'h9000_0004;
      smp();
      chk_resp("b2b_def_err1a", 1'b0, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("b2b_def_err2a", 1'b1, 2'b01, 32'h0);
      cyc();
      htrans = 2'b00;
      smp();
      chk_resp("b2b_def_err1b", 1'b0, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("b2b_def_err2b", 1'b1, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("b2b_def_okay", 1'b1, 2'b00, 32'h0);

      // Slave 0 (two waits) followed by slave 1
      cyc();
      haddr  = 32'h1000_0000;
      htrans = 2'b10;
      hrdata_s[31:0]  = 32'h1111_0000;
      hrdata_s[63:32] = 32'h2222_2222;
      smp();
      chk("b2b_s0_hsel", {28'd0, hsel_s}, 32'h1);
      cyc();
      haddr  = 32'h2000_0000;
      hreadyout_s[0] = 1'b0;
      smp();
      chk("b2b_w1_hsel", {28'd0, hsel_s}, 32'h2);
      chk("b2b_w1_hready", {31'd0, hready}, 32'h0);
      cyc();
      smp();
      chk("b2b_w2_hready", {31'd0, hready}, 32'h0);
      cyc();
      hreadyout_s[0] = 1'b1;
      hrdata_s[31:0] = 32'h1111_1111;
      smp();
      chk_resp("b2b_s0_data", 1'b1, 2'b00, 32'h1111_1111);
      cyc();
      htrans = 2'b00;
      smp();
      chk_resp("b2b_s1_data", 1'b1, 2'b00, 32'h2222_2222);
      cyc();
      smp();
      chk_resp("b2b_after", 1'b1, 2'b00, 32'h0);

      // Slave 0 stuck in wait state
      cyc();
      haddr  = 32'h1000_0040;
      htrans = 2'b10;
      hrdata_s[31:0] = 32'h5555_5555;
      cyc();
      htrans = 2'b00;
      hreadyout_s[0] = 1'b0;
`ifdef AHB_DEC_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         smp();
         chk($sformatf("to_wait%0d_irq", k), {31'd0, timeout_irq}, 32'h0);
         chk($sformatf("to_wait%0d_hready", k), {31'd0, hready}, 32'h0);
         cyc();
      end
      hreadyout_s[0] = 1'b1;
      smp();
      chk("to_irq_pulse", {31'd0, timeout_irq}, 32'h1);
      chk_resp("to_err1", 1'b0, 2'b01, 32'h0);
      cyc();
      smp();
      chk("to_irq_clear", {31'd0, timeout_irq}, 32'h0);
      chk_resp("to_err2", 1'b1, 2'b01, 32'h0);
      cyc();
      smp();
      chk_resp("to_okay", 1'b1, 2'b00, 32'h0);
      cyc();
      haddr  = 32'h1000_0080;
      htrans = 2'b10;
      cyc();
      htrans = 2'b00;
      hreadyout_s[0] = 1'b0;
`else
      for (int k = 1; k <= 10; k++) begin
         smp();
         chk($sformatf("stall%0d_irq", k), {31'd0, timeout_irq}, 32'h0);
         chk($sformatf("stall%0d_hready", k), {31'd0, hready}, 32'h0);
         cyc();
      end
`endif

      // Asynchronous reset in the middle of a wait state
      smp();
      chk("rstmid_pre_hready", {31'd0, hready}, 32'h0);
      #1 rst = 1'b1;
      #1;
      chk_resp("rstmid", 1'b1, 2'b00, 32'h0);
      chk("rstmid_irq", {31'd0, timeout_irq}, 32'h0);
      cyc();
      hreadyout_s[0] = 1'b1;
      rst = 1'b0;
      cyc();
      smp();
      chk_resp("post_rst", 1'b1, 2'b00, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
